data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the multicycle core's MEMORY stage.
- The main controller issues a single load or store request (read/write strobe, funct3 size code, byte address, store data).
- This block accepts the request, waits a configurable number of cycles, and performs the access on an internal word-organised data array. It then returns one `memReady` pulse with load data, or an error flag.
- The controller holds its MEMORY state until `memReady`, so this block is the other end of that handshake.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the data array (power of two, ≥4).
- LATENCY, 2, clock edges from request acceptance to the edge that raises `memReady` (≥1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- memRead  input  1  load request strobe
- memWrite  input  1  store request strobe
- funct3  input  3  access size/sign code (RV32I load/store funct3)
- addr  input  32  byte address
- writeData  input  32  store data; low bytes used for SB/SH
- readData  output  32  load result, sign/zero extended
- memReady  output  1  one-cycle response pulse
- memError  output  1  request was faulted; valid only while `memReady`=1
- busy  output  1  request in flight (state ≠ IDLE)

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (`rst_n`=0 at an edge):
  - state := IDLE; `readData`=0, `memReady`=0, `memError`=0, `busy`=0.
  - Array contents are not reset.
  - Reset mid-operation aborts the request. A store not yet committed is never written. No `memReady` is issued for the aborted request.
- States and transitions:
  - IDLE: a request is accepted at an edge where `memRead` or `memWrite` is 1. At that edge, capture `addr`, `funct3`, `writeData` and the request type, load the wait counter with LATENCY-1, then go to WAIT.
  - WAIT: decrement the counter each edge. When the counter is 0, go to RESPOND.
  - RESPOND: `memReady`=1 for exactly this one cycle, then IDLE at the next edge. Inputs are ignored in WAIT and RESPOND.
- Latency: request sampled at edge E0; `memReady` is high in the cycle after edge E0+LATENCY. With LATENCY=1, WAIT lasts zero extra cycles: the block goes IDLE→RESPOND via a single WAIT evaluation at edge E0+1.
- Access commit:
  - Happens on the edge entering RESPOND.
  - Stores write the array on that edge.
  - Loads register `readData` on that edge.
  - `readData` holds its value until the next load commits; stores and faults leave it unchanged.
- Load decode (little-endian, byte lane = `addr[1:0]`):
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended halfword.
- Store decode:
  - 000 SB: write `writeData[7:0]` into the addressed byte lane only.
  - 001 SH: write `writeData[15:0]` into the addressed halfword.
  - 010 SW: write the full word.
  - Unaddressed bytes are preserved.
- Word index = `addr[log2(DEPTH_WORDS)+1:2]`.
- Fault conditions (`memError`=1 with `memReady`; no array write; `readData` unchanged):
  - `memRead` and `memWrite` both 1 at acceptance.
  - Illegal funct3 for the request type (loads: 011, 110, 111; stores: anything except 000/001/010).
  - Misaligned access: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - `addr` ≥ 4·DEPTH_WORDS.
- Faulted requests still take the full LATENCY, so timing is uniform.
- Requester protocol: strobes must be low by the cycle after `memReady`. A strobe still high in IDLE is treated as a new request.
- `busy` = (state ≠ IDLE), combinational from the state register.

Test Plan:
- Reset then idle: `rst_n`=0 for 2 edges, strobes low → `readData`=0, `memReady`=0, `busy`=0 for 10 cycles.
- SW then LW, LATENCY=2:
  - SW `addr`=0x10, `writeData`=0xDEADBEEF → `memReady` in the cycle after the 2nd edge following acceptance, `memError`=0.
  - LW 0x10 → `readData`=0xDEADBEEF.
- Byte/half extension, word 0x10 = 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x10 → 0xFFFFBEEF.
  - LHU 0x12 → 0x0000DEAD.
- Partial store: SB `addr`=0x11, `writeData`=0x000000AA → subsequent LW 0x10 = 0xDEADAAEF.
- Faults:
  - LW 0x12 → `memError`=1, `readData` unchanged.
  - SH 0x11 → `memError`=1, word unchanged.
  - `memRead`=`memWrite`=1 → `memError`=1.
  - LW 0x1000 with DEPTH_WORDS=1024 → `memError`=1.
  - funct3=011 load → `memError`=1.
- Reset mid-store: SW 0x20 = 0x12345678 accepted, `rst_n`=0 during WAIT → no `memReady`; subsequent LW 0x20 returns the prior value; `busy`=0 after the reset edge.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: latency-configurable load/store responder closing the MEMORY-stage handshake
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memReady,
  output logic        memError,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rd, r_wr, r_ready, r_err;
  logic [2:0]    r_f3;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_word, w_shift, w_load, w_wsh;
  logic [3:0]    w_be;
  logic          w_bad_f3, w_mis, w_oob, w_fault, w_commit, w_we;
  assign w_idx    = r_addr[AW+1:2];
  assign w_lane   = r_addr[1:0];
  assign w_word   = r_mem[w_idx];
  assign w_bad_f3 = r_wr ? (r_f3 > 3'd2) : (r_f3 == 3'd3 || r_f3[2:1] == 2'b11);
  assign w_mis    = (r_f3[1:0] == 2'd1 && r_addr[0]) || (r_f3[1:0] == 2'd2 && r_addr[1:0] != 2'd0);
  assign w_oob    = |r_addr[31:AW+2];
  assign w_fault  = (r_rd && r_wr) || w_bad_f3 || w_mis || w_oob;
  assign w_commit = r_state == WAIT && r_cnt == '0;
  assign w_we     = rst_n && w_commit && r_wr && !w_fault;
  assign w_shift  = w_word >> {w_lane, 3'b000};
  // funct3[2] selects zero extension for LBU/LHU
  assign w_load   = r_f3[1:0] == 2'd0 ? {{24{~r_f3[2] & w_shift[7]}}, w_shift[7:0]} :
                    r_f3[1:0] == 2'd1 ? {{16{~r_f3[2] & w_shift[15]}}, w_shift[15:0]} : w_shift;
  assign w_be     = r_f3[1:0] == 2'd0 ? 4'b0001 << w_lane :
                    r_f3[1:0] == 2'd1 ? 4'b0011 << w_lane : 4'b1111;
  assign w_wsh    = r_f3[1:0] == 2'd0 ? {4{r_wdata[7:0]}} :
                    r_f3[1:0] == 2'd1 ? {2{r_wdata[15:0]}} : r_wdata;
  assign readData = r_rdata;
  assign memReady = r_ready;
  assign memError = r_err;
  assign busy     = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: if (memRead || memWrite) begin
          r_rd    <= memRead;
          r_wr    <= memWrite;
          r_f3    <= funct3;
          r_addr  <= addr;
          r_wdata <= writeData;
          r_cnt   <= CW'(LATENCY - 1);
          r_state <= WAIT;
        end
        WAIT: if (r_cnt == '0) begin
          r_state <= RESPOND;
          r_ready <= 1'b1;
          r_err   <= w_fault;
          if (r_rd && !r_wr && !w_fault) r_rdata <= w_load;
        end else r_cnt <= r_cnt - 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (w_we)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b+:8] <= w_wsh[8*b+:8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder load/store/fault/reset behaviour
module tb_data_mem_responder;
  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY = 2;
  typedef struct packed {logic err; logic [31:0] data;} exp_t;
  logic        clk = 1'b0, rst_n, memRead, memWrite, memReady, memError, busy;
  logic [2:0]  funct3;
  logic [31:0] addr, writeData, readData, last_rd;
  int          n_chk = 0, n_fail = 0;
  exp_t        q[$];
  data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
    .addr(addr), .writeData(writeData), .readData(readData), .memReady(memReady),
    .memError(memError), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (memReady) begin
      if (q.size() == 0) chk("unexpected_ready", 32'(memReady), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_err", 32'(memError), 32'(e.err));
        chk("sb_data", readData, e.data);
      end
    end
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic err, input logic [31:0] exp_ld);
    exp_t e;
    int cyc = 0;
    if (rd && !wr && !err) last_rd = exp_ld;
    e.err = err;
    e.data = last_rd;
    q.push_back(e);
    @(negedge clk);
    memRead = rd; memWrite = wr; funct3 = f3; addr = a; writeData = wd;
    @(posedge clk);
    #1 memRead = 1'b0; memWrite = 1'b0;
    chk("busy_accept", 32'(busy), 32'd1);
    do begin @(negedge clk); cyc++; end while (!memReady && cyc < 20);
    chk("latency", cyc, LATENCY + 1);
    @(negedge clk);
    chk("ready_pulse", 32'(memReady), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask
  initial begin
    rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = '0; addr = '0; writeData = '0; last_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("rst_rdata", readData, 32'd0);
      chk("rst_ready", 32'(memReady), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
    do_req(1, 0, 3'b010, 32'h10, 0, 0, 32'hDEADBEEF);
    do_req(1, 0, 3'b000, 32'h13, 0, 0, 32'hFFFFFFDE);
    do_req(1, 0, 3'b100, 32'h13, 0, 0, 32'h000000DE);
    do_req(1, 0, 3'b001, 32'h10, 0, 0, 32'hFFFFBEEF);
    do_req(1, 0, 3'b101, 32'h12, 0, 0, 32'h0000DEAD);
    do_req(0, 1, 3'b000, 32'h11, 32'h000000AA, 0, 0);
    do_req(1, 0, 3'b010, 32'h10, 0, 0, 32'hDEADAAEF);
    do_req(1, 0, 3'b010, 32'h12, 0, 1, 0);
    do_req(0, 1, 3'b001, 32'h11, 32'h00001234, 1, 0);
    do_req(1, 0, 3'b010, 32'h10, 0, 0, 32'hDEADAAEF);
    do_req(1, 1, 3'b010, 32'h10, 32'h0, 1, 0);
    do_req(1, 0, 3'b010, 32'h1000, 0, 1, 0);
    do_req(1, 0, 3'b011, 32'h10, 0, 1, 0);
    do_req(0, 1, 3'b100, 32'h10, 32'h11111111, 1, 0);
    do_req(1, 0, 3'b010, 32'h10, 0, 0, 32'hDEADAAEF);
    do_req(0, 1, 3'b001, 32'h12, 32'hFFFF1234, 0, 0);
    do_req(1, 0, 3'b010, 32'h10, 0, 0, 32'h1234AAEF);
    do_req(1, 0, 3'b000, 32'h10, 0, 0, 32'hFFFFFFEF);
    do_req(0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 0);
    @(negedge clk);
    memWrite = 1'b1; funct3 = 3'b010; addr = 32'h20; writeData = 32'h12345678;
    @(posedge clk);
    #1 memWrite = 1'b0;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(memReady), 32'd0);
    chk("abort_rdata", readData, 32'd0);
    last_rd = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(memReady), 32'd0);
    end
    do_req(1, 0, 3'b010, 32'h20, 0, 0, 32'hCAFEF00D);
    chk("sb_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
